// File: rtl/kp_scanner.sv
// kp_scanner: 4x4 keypad column scanner with press/release debounce and a key-code queue.
// Latency: a write lands one clock after the DEB_CNT-th matching sample strobe; key_valid is high on the next clock.
// Backpressure: key_valid/key_ready handshake. The scan never stalls; a press that finds the queue full is dropped and overflow sets.
// Ports: clk/reset (sync, active-high); kpc = active-low column drive; kphit/num = decoder result;
//        key_valid/key_num/key_ready = queue head handshake; overflow = sticky dropped-press flag.
module kp_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] kpc,
    input  logic       kphit,
    input  logic [3:0] num,
    output logic       key_valid,
    output logic [3:0] key_num,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_DEB  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;
    localparam logic [1:0] ST_HELD = 2'd3;

    // Column dwell divider; the last count of each dwell is the sample strobe.
    logic [DIV_W-1:0] div;
    logic             strobe;

    assign strobe = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Scan / debounce controller
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       kpc_next;
    logic             push;

    assign cnt_inc  = cnt + 1'b1;
    // Rotate the single low bit one position right: 0111 -> 1011 -> 1101 -> 1110 -> 0111.
    assign kpc_next = {kpc[0], kpc[3:1]};
    assign push     = (state == ST_PUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SCAN;
            kpc   <= 4'b0111;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (strobe) begin
                        if (kphit) begin
                            cand  <= num;
                            cnt   <= CNT_W'(1);
                            state <= (DEB_CNT == 1) ? ST_PUSH : ST_DEB;
                        end else begin
                            kpc <= kpc_next;
                        end
                    end
                end
                ST_DEB: begin
                    if (strobe) begin
                        if (kphit && (num == cand)) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DEB_LAST) begin
                                state <= ST_PUSH;
                            end
                        end else begin
                            // Bounce: give up on this column and keep scanning.
                            cnt   <= '0;
                            kpc   <= kpc_next;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_PUSH: begin
                    cnt   <= '0;
                    state <= ST_HELD;
                end
                ST_HELD: begin
                    // Count consecutive released samples; any hit restarts the release debounce.
                    if (strobe) begin
                        if (kphit) begin
                            cnt <= '0;
                        end else if (cnt_inc == DEB_LAST) begin
                            cnt   <= '0;
                            kpc   <= kpc_next;
                            state <= ST_SCAN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

    // Key-code queue. A pop in the same cycle as a push into a full queue frees the slot,
    // so the push is still taken; there is no bypass from an empty queue.
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full      = (count == FULL_CNT);
    assign key_valid = (count != '0);
    assign key_num   = mem[rd_ptr];
    assign pop       = key_valid & key_ready;
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= cand;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kp_scanner.sv
// tb_kp_scanner: randomized and directed stimulus for kp_scanner against a strobe-level keypad/queue model.
// Latency: n/a (bench).
// Backpressure: key_ready driven per scenario (held low, raised, or random).
module tb_kp_scanner;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kpc;
    logic       kphit;
    logic [3:0] num;
    logic       key_valid;
    logic [3:0] key_num;
    logic       key_ready = 1'b0;
    logic       overflow;

    logic       key_down = 1'b0;
    logic [3:0] key_code = 4'h0;

    always #5 clk = ~clk;

    kp_scanner #(.SCAN_DIV(SD), .DEB_CNT(DC), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .kpc       (kpc),
        .kphit     (kphit),
        .num       (num),
        .key_valid (key_valid),
        .key_num   (key_num),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    // Keypad layout: columns {1,4,7,*}, {2,5,8,0}, {3,6,9,#}, {A,B,C,D}; * = 14, # = 15.
    function automatic int col_of(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd7, 4'd14: return 0;
            4'd2, 4'd5, 4'd8, 4'd0:  return 1;
            4'd3, 4'd6, 4'd9, 4'd15: return 2;
            default:                 return 3;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one;
        one = 4'b1000;
        return ~(one >> c);
    endfunction

    // Single-key keypad + decoder: the key shows up only while its column is driven.
    assign kphit = key_down && (kpc == col_drive(col_of(key_code)));
    assign num   = kphit ? key_code : 4'h0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    // Reference model, advanced once per clock edge, decisions made once per sample strobe.
    int         exp_col;
    int         ph;
    int         run;
    int         rel;
    bit         lock;
    bit         acc;
    bit         push_pend;
    bit         ovf_m;
    logic [3:0] cand_m;
    logic [3:0] q[$];
    logic [3:0] got[$];

    task automatic model_reset();
        exp_col = 0; ph = 0; run = 0; rel = 0;
        lock = 0; acc = 0; push_pend = 0; ovf_m = 0;
        cand_m = 4'h0;
        q.delete();
    endtask

    task automatic strobe_step();
        bit hit;
        hit = key_down && (col_of(key_code) == exp_col);
        if (!lock) begin
            if (hit) begin
                lock = 1; acc = 0; run = 1; cand_m = key_code;
                if (run == DC) begin acc = 1; rel = 0; push_pend = 1; end
            end else begin
                exp_col = (exp_col + 1) % 4;
            end
        end else if (!acc) begin
            if (hit && key_code == cand_m) begin
                run++;
                if (run == DC) begin acc = 1; rel = 0; push_pend = 1; end
            end else begin
                lock = 0;
                exp_col = (exp_col + 1) % 4;
            end
        end else begin
            if (hit) rel = 0;
            else rel++;
            if (rel == DC) begin
                lock = 0;
                exp_col = (exp_col + 1) % 4;
            end
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (q.size() != 0 && key_ready) void'(q.pop_front());
            if (push_pend) begin
                push_pend = 0;
                if (q.size() < FD) q.push_back(cand_m);
                else ovf_m = 1;
            end
            if (ph == SD - 1) strobe_step();
            ph = (ph + 1) % SD;
        end
    endtask

    // One clock: check outputs mid-cycle, then apply this cycle's inputs and advance the model.
    task automatic cycle(input logic r, input logic dn, input logic [3:0] k, input logic rd);
        @(negedge clk);
        chk("kpc", 32'(kpc), 32'(col_drive(exp_col)));
        chk("key_valid", 32'(key_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("key_num", 32'(key_num), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        reset = r; key_down = dn; key_code = k; key_ready = rd;
        if (!r && key_valid && rd) got.push_back(key_num);
        model_edge();
    endtask

    task automatic idle(input int n, input logic rd);
        repeat (n) cycle(1'b0, 1'b0, 4'h0, rd);
    endtask

    task automatic hold(input logic [3:0] k, input int n, input logic rd);
        repeat (n) cycle(1'b0, 1'b1, k, rd);
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (!(exp_col == c && ph == 0) && n < 64) begin
            idle(1, 1'b0);
            n++;
        end
        chk("align_timeout", 32'(n < 64), 32'd1);
    endtask

    task automatic chk_got(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3, input logic [3:0] e4,
                           input int n);
        logic [3:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_code"}, 32'(got[i]), 32'(e[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        bit saw_push;

        model_reset();
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("rst_kpc", 32'(kpc), 32'h7);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_num", 32'(key_num), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Idle scan: one column per SD clocks, in rotation order.
        for (int k = 0; k < 64; k++) begin
            idle(1, 1'b0);
            chk("idle_kpc", 32'(kpc), 32'(col_drive((k / SD) % 4)));
            chk("idle_valid", 32'(key_valid), 32'd0);
        end

        // "5" held 40 clocks then released.
        got.delete();
        hold(4'd5, 40, 1'b0);
        chk("t5_freeze", 32'(kpc), 32'hB);
        idle(40, 1'b0);
        idle(8, 1'b1);
        chk_got("t5", 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1);

        // "9" bounce: one hit strobe, one miss strobe, then steady.
        wait_col(2);
        got.delete();
        hold(4'd9, SD, 1'b0);
        idle(SD, 1'b0);
        hold(4'd9, 1, 1'b0);
        chk("t9_reject_kpc", 32'(kpc), 32'hE);
        hold(4'd9, 60, 1'b0);
        idle(30, 1'b0);
        idle(8, 1'b1);
        chk_got("t9", 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 1);

        // Five presses with no consumer: fourth fills, fifth overflows.
        got.delete();
        seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd10; seq[4] = 4'd11;
        for (int i = 0; i < 5; i++) begin
            hold(seq[i], 40, 1'b0);
            idle(30, 1'b0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        idle(8, 1'b1);
        chk_got("ovf", 4'd1, 4'd2, 4'd3, 4'd10, 4'd0, 4);
        chk("ovf_drained", 32'(key_valid), 32'd0);

        // Reset during the debounce of "4" with a code already queued.
        hold(4'd6, 40, 1'b0);
        idle(30, 1'b0);
        wait_col(0);
        hold(4'd4, SD, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("mrst_kpc", 32'(kpc), 32'h7);
        chk("mrst_valid", 32'(key_valid), 32'd0);
        chk("mrst_overflow", 32'(overflow), 32'd0);
        got.delete();
        idle(40, 1'b1);
        chk("mrst_no_code", 32'(got.size()), 32'd0);

        // Full queue with a pop in the very cycle "7" is written.
        got.delete();
        for (int i = 0; i < 4; i++) begin
            hold(seq[i], 40, 1'b0);
            idle(30, 1'b0);
        end
        saw_push = 0;
        for (int i = 0; i < 60; i++) begin
            if (push_pend) saw_push = 1;
            cycle(1'b0, 1'(i < 40), 4'd7, 1'(push_pend));
        end
        chk("full_push_seen", 32'(saw_push), 32'd1);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        idle(8, 1'b1);
        chk_got("full", 4'd1, 4'd2, 4'd3, 4'd10, 4'd7, 5);

        // Random presses, glitches and consumer stalls.
        for (int i = 0; i < 12; i++) begin
            logic [3:0] k;
            logic [3:0] g;
            k = 4'($urandom_range(0, 15));
            g = 4'($urandom_range(0, 15));
            repeat ($urandom_range(40, 60)) cycle(1'b0, 1'b1, k, 1'($urandom_range(0, 1)));
            repeat (16) cycle(1'b0, 1'b0, 4'h0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 2 * SD)) cycle(1'b0, 1'b1, g, 1'($urandom_range(0, 1)));
            repeat (16) cycle(1'b0, 1'b0, 4'h0, 1'($urandom_range(0, 1)));
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
